// File: rtl/rv32i_types.sv
// Shared RV32I core types: common data bus record and its default sizing.
package rv32i_types;

    localparam int unsigned CDB_UNITS     = 4;
    localparam int unsigned CDB_ROB_IDX_W = 4;
    localparam int unsigned CDB_DATA_W    = 32;
    localparam int unsigned CDB_SRC_W     = $clog2(CDB_UNITS);

    // One broadcast on the CDB, as consumed by the ROB and reservation stations.
    typedef struct packed {
        logic                     valid;
        logic [CDB_ROB_IDX_W-1:0] rob_id;
        logic [CDB_DATA_W-1:0]    data;
    } cdb_t;

    // Index width for a set of n items; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_arbiter
    import rv32i_types::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Scan N slots starting at ptr; the first asserted request wins.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!any && req[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                grant_idx       = IW'(idx);
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per EX unit, round-robin
// broadcast of one pending result per cycle, flush and reset discard.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter  int unsigned N_UNITS   = CDB_UNITS,
    parameter  int unsigned ROB_IDX_W = CDB_ROB_IDX_W,
    parameter  int unsigned DATA_W    = CDB_DATA_W,
    localparam int unsigned SRC_W     = idx_w(N_UNITS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [N_UNITS-1:0]                  req_valid,
    input  logic [N_UNITS-1:0][ROB_IDX_W-1:0]   req_rob_id,
    input  logic [N_UNITS-1:0][DATA_W-1:0]      req_data,
    output logic [N_UNITS-1:0]                  req_ready,
    output logic                                cdb_valid,
    output logic [ROB_IDX_W-1:0]                cdb_rob_id,
    output logic [DATA_W-1:0]                   cdb_data,
    output logic [SRC_W-1:0]                    cdb_src
);

    logic [N_UNITS-1:0]                hold_valid;
    logic [N_UNITS-1:0][ROB_IDX_W-1:0] hold_rob_id;
    logic [N_UNITS-1:0][DATA_W-1:0]    hold_data;
    logic [SRC_W-1:0]                  rr_ptr;

    logic [N_UNITS-1:0] grant;
    logic [N_UNITS-1:0] grant_eff;
    logic [N_UNITS-1:0] accept;
    logic [SRC_W-1:0]   grant_idx;
    logic               any;

    rr_arbiter #(.N(N_UNITS)) u_arb (
        .req       (hold_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Broadcast the winner; a granted slot frees up in the same cycle so its unit may refill.
    always_comb begin
        cdb_valid  = any & ~flush & ~rst;
        grant_eff  = grant & {N_UNITS{cdb_valid}};
        req_ready  = (~hold_valid | grant_eff) & {N_UNITS{~flush}};
        accept     = req_valid & req_ready;
        cdb_rob_id = hold_rob_id[grant_idx];
        cdb_data   = hold_data[grant_idx];
        cdb_src    = grant_idx;
    end

    // Occupancy and rotation pointer; reset outranks flush, flush leaves rr_ptr alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            if (flush) hold_valid <= '0;
            else       hold_valid <= accept | (hold_valid & ~grant_eff);
            if (cdb_valid)
                rr_ptr <= (grant_idx == SRC_W'(N_UNITS - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    // Payload capture on accept; contents are meaningless while the slot is invalid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            if (accept[i]) begin
                hold_rob_id[i] <= req_rob_id[i];
                hold_data[i]   <= req_data[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random traffic,
// all compared against a slot-level reference model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int RW = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [N-1:0]             req_valid;
    logic [N-1:0][RW-1:0]     req_rob_id;
    logic [N-1:0][DW-1:0]     req_data;
    logic [N-1:0]             req_ready;
    logic                     cdb_valid;
    logic [RW-1:0]            cdb_rob_id;
    logic [DW-1:0]            cdb_data;
    logic [SW-1:0]            cdb_src;

    cdb_arbiter #(.N_UNITS(N), .ROB_IDX_W(RW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_rob_id (req_rob_id),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_data   (cdb_data),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Reference model: which units have a pending result, its payload, and whose turn it is.
    bit            m_pend [N];
    logic [RW-1:0] m_rob  [N];
    logic [DW-1:0] m_dat  [N];
    int            m_ptr;
    bit            accepted [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req_valid = '0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        int           win;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        win = -1;
        if (!rst && !flush) begin
            for (int k = 0; k < N; k++) begin
                int u;
                u = (m_ptr + k) % N;
                if (win < 0 && m_pend[u]) win = u;
            end
        end
        for (int i = 0; i < N; i++)
            exp_ready[i] = !flush && (!m_pend[i] || i == win);
        check("cdb_valid", 64'(cdb_valid), 64'(win >= 0));
        if (win >= 0) begin
            check("cdb_rob_id", 64'(cdb_rob_id), 64'(m_rob[win]));
            check("cdb_data",   64'(cdb_data),   64'(m_dat[win]));
            check("cdb_src",    64'(cdb_src),    64'(win));
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < N; i++)
            accepted[i] = !rst && req_valid[i] && exp_ready[i];
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_ptr = 0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        end else begin
            if (win >= 0) m_pend[win] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (accepted[i]) begin
                    m_pend[i] = 1'b1;
                    m_rob[i]  = req_rob_id[i];
                    m_dat[i]  = req_data[i];
                end
            end
            if (win >= 0) m_ptr = (win + 1) % N;
        end
        #1;
    endtask

    task automatic present(input int u, input logic [RW-1:0] rob, input logic [DW-1:0] dat);
        req_valid[u]  = 1'b1;
        req_rob_id[u] = rob;
        req_data[u]   = dat;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = '0;
        req_rob_id = '0;
        req_data   = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_rob[i]  = '0;
            m_dat[i]  = '0;
        end
        m_ptr = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: no broadcast, then all units ready with rr_ptr at 0.
        cycle();
        idle();
        cycle();
        check("rr_ptr_reset", 64'(dut.rr_ptr), 64'd0);

        // Single request from unit 2.
        present(2, 4'd5, 32'hDEADBEEF);
        cycle();
        idle();
        cycle();
        check("rr_ptr_single", 64'(dut.rr_ptr), 64'd3);

        // Steer rr_ptr to 1 via a lone grant to unit 0.
        present(0, 4'd1, 32'h0000_1111);
        cycle();
        idle();
        cycle();
        check("rr_ptr_to1", 64'(dut.rr_ptr), 64'd1);

        // Four-way contention starting from rr_ptr=1: expected order 1,2,3,0.
        for (int i = 0; i < N; i++) present(i, 4'(8 + i), $urandom);
        cycle();
        idle();
        repeat (4) cycle();

        // Streaming from unit 0, rob_id 0..7 back to back.
        for (int r = 0; r < 8; r++) begin
            present(0, 4'(r), $urandom);
            cycle();
        end
        idle();
        repeat (2) cycle();

        // Same-cycle refill on unit 1.
        present(1, 4'd3, 32'hAAAA_0003);
        cycle();
        present(1, 4'd4, 32'hBBBB_0004);
        cycle();
        idle();
        repeat (2) cycle();

        // Flush with units 0 and 3 pending.
        present(0, 4'd6, 32'h6666_6666);
        present(3, 4'd7, 32'h7777_7777);
        cycle();
        idle();
        flush = 1'b1;
        present(1, 4'd9, 32'h9999_9999);
        cycle();
        idle();
        cycle();

        // Reset mid-operation with all four units pending.
        for (int i = 0; i < N; i++) present(i, 4'(12 + i), $urandom);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("rr_ptr_midreset", 64'(dut.rr_ptr), 64'd0);
        present(3, 4'd2, 32'h3333_0002);
        cycle();
        idle();
        cycle();

        // Random traffic; a stalled unit keeps its request stable until accepted.
        for (int i = 0; i < N; i++) accepted[i] = 1'b1;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !accepted[i])) begin
                    req_valid[i]  = ($urandom_range(0, 9) < 6);
                    req_rob_id[i] = 4'($urandom);
                    req_data[i]   = $urandom;
                end
            end
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 59) == 0);
            cycle();
        end
        idle();
        repeat (N + 1) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
